// File: rtl/pulse_gen.sv
// Pulse/square oscillator with programmable period, duty cycle and signed amplitude.
// Optional hard-sync input: define PULSE_GEN_HARD_SYNC_EN to add sync_in.
`timescale 1ns / 1ps
module pulse_gen #(
    parameter int unsigned CLK_FREQ = 100_000_000,
    parameter int unsigned CTR_W    = 24,
    parameter int unsigned DATA_W   = 16
) (
    input  logic                     clk_in,
    input  logic                     reset_n,
    input  logic                     enable,
    input  logic [CTR_W-1:0]         period_in,
    input  logic [CTR_W-1:0]         duty_in,
    input  logic signed [DATA_W-1:0] amp_in,
    input  logic                     load,
`ifdef PULSE_GEN_HARD_SYNC_EN
    input  logic                     sync_in,
`endif
    output logic                     load_ack,
    output logic signed [DATA_W-1:0] pulse_out,
    output logic                     wrap_out
);

    localparam logic signed [DATA_W-1:0] AmpMin = {1'b1, {(DATA_W - 1) {1'b0}}};
    localparam logic signed [DATA_W-1:0] AmpMax = {1'b0, {(DATA_W - 1) {1'b1}}};

    // CLK_FREQ only documents the clock the design is timed against.
    if (CLK_FREQ == 0) begin : g_clk_freq_unset
    end

    typedef enum logic {StIdle, StRun} state_e;

    state_e                   state_q, state_d;
    logic [CTR_W-1:0]         ctr_q, ctr_d, pos;
    logic [CTR_W-1:0]         stg_per_q, stg_duty_q, shd_per_q, shd_duty_q;
    logic [CTR_W-1:0]         eff_per, eff_duty;
    logic signed [DATA_W-1:0] stg_amp_q, shd_amp_q, eff_amp, neg_amp;
    logic signed [DATA_W-1:0] pulse_q, pulse_d;
    logic                     pend_q, pend_d;
    logic                     wrap_q, wrap_d;
    logic                     ack_q;
    logic                     apply, active, boundary, sync;

`ifdef PULSE_GEN_HARD_SYNC_EN
    assign sync = sync_in;
`else
    assign sync = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        ctr_d    = ctr_q;
        pulse_d  = '0;
        wrap_d   = 1'b0;
        active   = 1'b0;
        boundary = 1'b0;
        pos      = ctr_q;

        unique case (state_q)
            StIdle: begin
                pos = '0;
                if (enable) begin
                    state_d  = StRun;
                    active   = 1'b1;
                    boundary = 1'b1;
                end
            end
            StRun: begin
                if (!enable) begin
                    state_d = StIdle;
                    ctr_d   = '0;
                end else begin
                    active = 1'b1;
                    // Natural wrap (ctr back at 0) and hard sync merge into one boundary.
                    if (sync || ctr_q == '0) begin
                        pos      = '0;
                        boundary = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Staged settings take effect on the very sample that starts the new period.
        apply    = pend_q && (state_q == StIdle || boundary);
        eff_per  = apply ? stg_per_q  : shd_per_q;
        eff_duty = apply ? stg_duty_q : shd_duty_q;
        eff_amp  = apply ? stg_amp_q  : shd_amp_q;
        neg_amp  = (eff_amp == AmpMin) ? AmpMax : -eff_amp;

        if (active) begin
            ctr_d   = (pos >= eff_per) ? '0 : pos + CTR_W'(1);
            pulse_d = (pos < eff_duty) ? eff_amp : neg_amp;
            wrap_d  = boundary;
        end

        // A load in the same cycle as an apply re-arms pending for the next boundary.
        if (load) begin
            pend_d = 1'b1;
        end else if (apply) begin
            pend_d = 1'b0;
        end else begin
            pend_d = pend_q;
        end
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            ctr_q      <= '0;
            pulse_q    <= '0;
            wrap_q     <= 1'b0;
            ack_q      <= 1'b0;
            pend_q     <= 1'b0;
            stg_per_q  <= '0;
            stg_duty_q <= '0;
            stg_amp_q  <= '0;
            shd_per_q  <= '0;
            shd_duty_q <= '0;
            shd_amp_q  <= '0;
        end else begin
            state_q <= state_d;
            ctr_q   <= ctr_d;
            pulse_q <= pulse_d;
            wrap_q  <= wrap_d;
            ack_q   <= apply;
            pend_q  <= pend_d;
            if (load) begin
                stg_per_q  <= period_in;
                stg_duty_q <= duty_in;
                stg_amp_q  <= amp_in;
            end
            if (apply) begin
                shd_per_q  <= stg_per_q;
                shd_duty_q <= stg_duty_q;
                shd_amp_q  <= stg_amp_q;
            end
        end
    end

    assign pulse_out = pulse_q;
    assign wrap_out  = wrap_q;
    assign load_ack  = ack_q;

endmodule

// File: tb/tb_pulse_gen.sv
// Self-checking bench for pulse_gen: period-level behavioural model plus directed literal checks.
`timescale 1ns / 1ps
module tb_pulse_gen;

    logic               clk_in = 1'b0;
    logic               reset_n;
    logic               enable;
    logic [23:0]        period_in;
    logic [23:0]        duty_in;
    logic signed [15:0] amp_in;
    logic               load;
    logic               sync_in;
    logic               load_ack;
    logic signed [15:0] pulse_out;
    logic               wrap_out;

    pulse_gen #(
        .CTR_W (24),
        .DATA_W(16)
    ) dut (
        .clk_in   (clk_in),
        .reset_n  (reset_n),
        .enable   (enable),
        .period_in(period_in),
        .duty_in  (duty_in),
        .amp_in   (amp_in),
        .load     (load),
`ifdef PULSE_GEN_HARD_SYNC_EN
        .sync_in  (sync_in),
`endif
        .load_ack (load_ack),
        .pulse_out(pulse_out),
        .wrap_out (wrap_out)
    );

    always #5 clk_in = ~clk_in;

    int errors = 0;
    int checks = 0;
    bit check_on = 1'b0;
    int cyc;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: settings held as whole periods; a new period starts after period+1 samples.
    int m_idx = 0;
    int s_per = 0, s_duty = 0, s_amp = 0;
    int g_per = 0, g_duty = 0, g_amp = 0;
    bit m_run = 1'b0, m_newp = 1'b1, m_pend = 1'b0;
    bit m_start, m_applied;
    int e_pulse = 0;
    bit e_wrap = 1'b0, e_ack = 1'b0;

    initial forever begin
        @(posedge clk_in or negedge reset_n);
        if (!reset_n) begin
            m_idx = 0; s_per = 0; s_duty = 0; s_amp = 0;
            g_per = 0; g_duty = 0; g_amp = 0;
            m_run = 1'b0; m_newp = 1'b1; m_pend = 1'b0;
            e_pulse = 0; e_wrap = 1'b0; e_ack = 1'b0;
        end else begin
            m_applied = 1'b0;
            e_pulse   = 0;
            e_wrap    = 1'b0;
            if (enable) begin
                m_start = !m_run || m_newp || (sync_in === 1'b1);
                if (m_start) begin
                    m_idx = 0;
                    if (m_pend) begin
                        s_per = g_per; s_duty = g_duty; s_amp = g_amp;
                        m_pend = 1'b0; m_applied = 1'b1;
                    end
                end
                e_pulse = (m_idx < s_duty) ? s_amp : ((s_amp == -32768) ? 32767 : -s_amp);
                e_wrap  = m_start;
                m_idx++;
                m_newp  = (m_idx > s_per);
                m_run   = 1'b1;
            end else begin
                if (!m_run && m_pend) begin
                    s_per = g_per; s_duty = g_duty; s_amp = g_amp;
                    m_pend = 1'b0; m_applied = 1'b1;
                end
                m_run  = 1'b0;
                m_newp = 1'b1;
            end
            e_ack = m_applied;
            if (load) begin
                g_per  = int'(period_in);
                g_duty = int'(duty_in);
                g_amp  = int'(amp_in);
                m_pend = 1'b1;
            end
        end
    end

    initial forever begin
        @(negedge clk_in);
        if (check_on) begin
            chk("model_pulse", int'(pulse_out), e_pulse);
            chk("model_wrap", int'(wrap_out), int'(e_wrap));
            chk("model_ack", int'(load_ack), int'(e_ack));
        end
    end

    task automatic load_params(input int per, input int duty, input int amp);
        load      = 1'b1;
        period_in = 24'(per);
        duty_in   = 24'(duty);
        amp_in    = 16'(amp);
        @(negedge clk_in);
        load = 1'b0;
    endtask

    task automatic wait_ack(input string name, output int cycles);
        cycles = 0;
        do begin
            @(negedge clk_in);
            cycles++;
        end while (!load_ack && cycles < 40);
        checks++;
        if (!load_ack) begin
            errors++;
            $display("FAIL %s: load_ack got 0 after %0d cycles, want 1", name, cycles);
        end
    endtask

    task automatic hold_level(input string name, input int n, input int exp);
        for (int i = 0; i < n; i++) begin
            chk(name, int'(pulse_out), exp);
            @(negedge clk_in);
        end
    endtask

    initial begin
        reset_n = 1'b0; enable = 1'b0; load = 1'b0; sync_in = 1'b0;
        period_in = '0; duty_in = '0; amp_in = '0;
        repeat (3) @(negedge clk_in);
        chk("reset_pulse", int'(pulse_out), 0);
        chk("reset_wrap", int'(wrap_out), 0);
        chk("reset_ack", int'(load_ack), 0);
        reset_n  = 1'b1;
        check_on = 1'b1;
        @(negedge clk_in);

        // 1. period 10, duty 5
        load_params(9, 5, 1000);
        enable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_in);
            chk("t1_pulse", int'(pulse_out), ((i % 10) < 5) ? 1000 : -1000);
            chk("t1_wrap", int'(wrap_out), ((i % 10) == 0) ? 1 : 0);
            if (i == 0) chk("t1_ack", int'(load_ack), 1);
        end

        // 2. mid-period update waits for the boundary
        repeat (3) @(negedge clk_in);
        load_params(3, 2, 1000);
        wait_ack("t2_ack", cyc);
        chk("t2_ack_delay", cyc, 7);
        chk("t2_first_pulse", int'(pulse_out), 1000);
        chk("t2_first_wrap", int'(wrap_out), 1);
        for (int i = 1; i < 8; i++) begin
            @(negedge clk_in);
            chk("t2_pulse", int'(pulse_out), ((i % 4) < 2) ? 1000 : -1000);
            chk("t2_wrap", int'(wrap_out), ((i % 4) == 0) ? 1 : 0);
        end

        // 3. edge values
        load_params(9, 0, 1000);
        wait_ack("t3a_ack", cyc);
        hold_level("t3a_duty0", 12, -1000);
        load_params(9, 20, 1000);
        wait_ack("t3b_ack", cyc);
        hold_level("t3b_duty_gt_period", 12, 1000);
        load_params(9, 0, -32768);
        wait_ack("t3c_ack", cyc);
        hold_level("t3c_saturate", 12, 32767);
        load_params(0, 0, 1000);
        wait_ack("t3d_ack", cyc);
        for (int i = 0; i < 6; i++) begin
            chk("t3d_wrap_high", int'(wrap_out), 1);
            @(negedge clk_in);
        end

        // 4. enable drop with a load pending across IDLE
        load_params(9, 5, 1000);
        wait_ack("t4_ack", cyc);
        chk("t4_start", int'(pulse_out), 1000);
        @(negedge clk_in);
        enable = 1'b0; load = 1'b1; amp_in = 16'sd2000;
        @(negedge clk_in);
        load = 1'b0;
        chk("t4_off_pulse", int'(pulse_out), 0);
        chk("t4_off_wrap", int'(wrap_out), 0);
        chk("t4_off_noack", int'(load_ack), 0);
        @(negedge clk_in);
        chk("t4_idle_ack", int'(load_ack), 1);
        chk("t4_idle_pulse", int'(pulse_out), 0);
        @(negedge clk_in);
        chk("t4_idle_ack_drop", int'(load_ack), 0);
        enable = 1'b1;
        @(negedge clk_in);
        chk("t4_restart_pulse", int'(pulse_out), 2000);
        chk("t4_restart_wrap", int'(wrap_out), 1);

        // 5. asynchronous reset mid-period
        repeat (3) @(negedge clk_in);
        #2 reset_n = 1'b0;
        #1;
        chk("t5_async_pulse", int'(pulse_out), 0);
        chk("t5_async_wrap", int'(wrap_out), 0);
        chk("t5_async_ack", int'(load_ack), 0);
        @(negedge clk_in);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_in);
            chk("t5_cleared_pulse", int'(pulse_out), 0);
        end

`ifdef PULSE_GEN_HARD_SYNC_EN
        // 6. hard sync at ctr=3
        load_params(9, 5, 1000);
        wait_ack("t6_ack", cyc);
        repeat (2) @(negedge clk_in);
        sync_in = 1'b1;
        @(negedge clk_in);
        sync_in = 1'b0;
        chk("t6_sync_wrap", int'(wrap_out), 1);
        chk("t6_sync_pulse", int'(pulse_out), 1000);
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk_in);
            chk("t6_period_wrap", int'(wrap_out), (i == 10) ? 1 : 0);
        end
`endif

        @(negedge clk_in);
        check_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1);
    end

endmodule
